serial_frame_rx: RTL and testbench



---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_frame_rx_sync_hunter.sv | 45 ++++
 rtl/serial_frame_rx.sv | 162 ++++++++++++++++
 tb/tb_serial_frame_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial framing blocks (serialiser, receiver,
// Moore detector): FSM state encodings and the default frame format.
package serial_pkg;

   // Receiver FSM state encodings
   localparam logic [1:0] ST_HUNT = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_PAR  = 2'd2;

   // Default frame format shared by all serial blocks
   localparam int         DATA_W_DEFAULT = 8;
   localparam int         SYNC_W_DEFAULT = 4;
   localparam logic [3:0] SYNC_DEFAULT   = 4'b1101;

endpackage : serial_pkg

// File: rtl/serial_frame_rx_sync_hunter.sv
// sync_hunter: SYNC_W-bit sliding window over the serial line with a
// compare against the sync header. hit is combinational on the value the
// window is about to take, so the FSM can leave HUNT on the same edge that
// samples the header's last bit. A hit clears the window so the header
// bits are never reused; clear holds the window at zero while the
// receiver is inside a frame.
module sync_hunter #(
   parameter int                SYNC_W = 4,
   parameter logic [SYNC_W-1:0] SYNC   = 4'b1101
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic din,
   input  logic clear,
   output logic hit
);

   logic [SYNC_W-1:0] window_r;
   logic [SYNC_W-1:0] window_nxt_s;

   // Next window value and header match on that value
   always_comb begin
      window_nxt_s = {window_r[SYNC_W-2:0], din};
      if (en && (window_nxt_s == SYNC)) begin
         hit = 1'b1;
      end else begin
         hit = 1'b0;
      end
   end

   // Window register: shift on enabled bits, clear on hit or on request
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         window_r <= {SYNC_W{1'b0}};
      end else if (en) begin
         if (hit) begin
            window_r <= {SYNC_W{1'b0}};
         end else begin
            window_r <= window_nxt_s;
         end
      end
   end

endmodule : sync_hunter

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts for a sync header on a 1-bit line, deserialises
// the following DATA_W bits MSB first, and reports each word with a
// one-cycle valid pulse plus a wrapping frame counter.
// Optional build macro SERIAL_FRAME_RX_PARITY_EN adds an even-parity bit
// after the payload (PAR state) and a parity_err output.
module serial_frame_rx
   import serial_pkg::*;
#(
   parameter int                DATA_W = DATA_W_DEFAULT,
   parameter int                SYNC_W = SYNC_W_DEFAULT,
   parameter logic [SYNC_W-1:0] SYNC   = SYNC_DEFAULT,
   parameter int                CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              din,
   output logic [DATA_W-1:0] data_o,
   output logic              valid,
   output logic              busy,
   output logic [CNT_W-1:0]  frame_cnt
`ifdef SERIAL_FRAME_RX_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int               BC_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic [DATA_W-1:0] sr_r;
   logic [DATA_W-1:0] sr_nxt_s;
   logic [BC_W-1:0]   bit_cnt_r;
   logic [BC_W-1:0]   bit_cnt_nxt_s;
   logic              done_s;
   logic [DATA_W-1:0] word_s;
   logic              hunt_en_s;
   logic              hunt_clr_s;
   logic              hit_s;

`ifdef SERIAL_FRAME_RX_PARITY_EN
   logic              perr_s;

   // Even parity check: nonzero XOR over payload and parity bit is an error
   function automatic logic parity_err_f(input logic [DATA_W-1:0] word,
                                         input logic              pbit);
      return ^{word, pbit};
   endfunction
`endif

   // The window only sees bits while hunting; payload bits never reach it
   always_comb begin
      if (state_r == ST_HUNT) begin
         hunt_en_s  = en;
         hunt_clr_s = 1'b0;
      end else begin
         hunt_en_s  = 1'b0;
         hunt_clr_s = 1'b1;
      end
   end

   sync_hunter #(
      .SYNC_W (SYNC_W),
      .SYNC   (SYNC)
   ) u_sync_hunter (
      .clk   (clk),
      .reset (reset),
      .en    (hunt_en_s),
      .din   (din),
      .clear (hunt_clr_s),
      .hit   (hit_s)
   );

   // Next-state, shift register and bit counter; flags frame completion
   always_comb begin
      state_nxt_s   = state_r;
      sr_nxt_s      = sr_r;
      bit_cnt_nxt_s = bit_cnt_r;
      done_s        = 1'b0;
      word_s        = sr_r;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      perr_s        = 1'b0;
`endif
      case (state_r)
         ST_HUNT: begin
            if (en && hit_s) begin
               state_nxt_s   = ST_DATA;
               bit_cnt_nxt_s = {BC_W{1'b0}};
            end else begin
               state_nxt_s   = ST_HUNT;
            end
         end
         ST_DATA: begin
            if (en) begin
               sr_nxt_s = {sr_r[DATA_W-2:0], din};
               if (bit_cnt_r == LAST_BIT) begin
                  bit_cnt_nxt_s = {BC_W{1'b0}};
`ifdef SERIAL_FRAME_RX_PARITY_EN
                  state_nxt_s   = ST_PAR;
`else
                  state_nxt_s   = ST_HUNT;
                  done_s        = 1'b1;
                  word_s        = {sr_r[DATA_W-2:0], din};
`endif
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + BC_W'(1);
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
`ifdef SERIAL_FRAME_RX_PARITY_EN
         ST_PAR: begin
            if (en) begin
               state_nxt_s = ST_HUNT;
               done_s      = 1'b1;
               word_s      = sr_r;
               perr_s      = parity_err_f(sr_r, din);
            end else begin
               state_nxt_s = ST_PAR;
            end
         end
`endif
         default: begin
            state_nxt_s   = ST_HUNT;
            bit_cnt_nxt_s = {BC_W{1'b0}};
         end
      endcase
   end

   // State, datapath and registered outputs; valid self-clears every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_HUNT;
         sr_r       <= {DATA_W{1'b0}};
         bit_cnt_r  <= {BC_W{1'b0}};
         data_o     <= {DATA_W{1'b0}};
         valid      <= 1'b0;
         busy       <= 1'b0;
         frame_cnt  <= {CNT_W{1'b0}};
`ifdef SERIAL_FRAME_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         state_r   <= state_nxt_s;
         sr_r      <= sr_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         busy      <= (state_nxt_s != ST_HUNT);
         valid     <= done_s;
         if (done_s) begin
            data_o     <= word_s;
            frame_cnt  <= frame_cnt + CNT_W'(1);
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err <= perr_s;
`endif
         end
      end
   end

endmodule : serial_frame_rx

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: stimulus pushes the expected word
// and frame count for every frame it sends; a negedge monitor pops and
// compares whenever valid is seen.
module tb_serial_frame_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       din = 1'b0;
   logic [7:0] data_o;
   logic       valid;
   logic       busy;
   logic [7:0] frame_cnt;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   logic       parity_err;
`endif

   typedef struct {
      logic [7:0] data;
      logic [7:0] cnt;
      logic       perr;
   } exp_t;

   exp_t       sb_q[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] model_cnt = 8'd0;
   logic       prev_valid = 1'b0;

   always #5 clk = ~clk;

   serial_frame_rx dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .din        (din),
      .data_o     (data_o),
      .valid      (valid),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
`ifdef SERIAL_FRAME_RX_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One enabled bit followed by gap idle cycles; called #1 after a posedge
   task automatic send_bit(input logic b, input int gap);
      en  = 1'b1;
      din = b;
      @(posedge clk); #1;
      en  = 1'b0;
      din = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic perr);
      exp_t e;
      model_cnt = model_cnt + 8'd1;
      e.data = d;
      e.cnt  = model_cnt;
      e.perr = perr;
      sb_q.push_back(e);
   endtask

   task automatic send_header(input int gap);
      logic [3:0] hdr;
      hdr = 4'b1101;
      for (int i = 3; i >= 0; i--) send_bit(hdr[i], gap);
   endtask

   task automatic send_payload(input logic [7:0] p, input int gap, input logic pflip);
      for (int i = 7; i >= 0; i--) send_bit(p[i], gap);
`ifdef SERIAL_FRAME_RX_PARITY_EN
      send_bit((^p) ^ pflip, gap);
`else
      if (pflip) begin
         $display("parity flip ignored in this build");
      end
`endif
   endtask

   task automatic send_frame(input logic [7:0] p, input int gap, input logic pflip);
      push_exp(p, pflip);
      send_header(gap);
      send_payload(p, gap, pflip);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
      model_cnt = 8'd0;
   endtask

   // Monitor: pop and compare on every valid; valid must never repeat
   always @(negedge clk) begin
      if (!reset && valid) begin
         checks++;
         if (prev_valid) begin
            errors++;
            $display("FAIL valid_pulse: valid high 2 cycles in a row at %0t", $time);
         end
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: data_o=0x%0h frame_cnt=%0d with empty scoreboard", data_o, frame_cnt);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("frame_data", {24'd0, data_o}, {24'd0, e.data});
            check("frame_cnt", {24'd0, frame_cnt}, {24'd0, e.cnt});
`ifdef SERIAL_FRAME_RX_PARITY_EN
            check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
`endif
         end
      end
      prev_valid = valid;
   end

   initial begin
      // Reset with random inputs: outputs stay at reset values
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         en  = 1'($urandom_range(0, 1));
         din = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("rst_data", {24'd0, data_o}, 32'd0);
         check("rst_valid", {31'd0, valid}, 32'd0);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_cnt", {24'd0, frame_cnt}, 32'd0);
      end
      @(posedge clk); #1;
      en = 1'b0;
      reset = 1'b0;
      model_cnt = 8'd0;

      // Basic frame 0xA5, busy rises right after the header
      push_exp(8'hA5, 1'b0);
      send_header(0);
      check("busy_after_hdr", {31'd0, busy}, 32'd1);
      send_payload(8'hA5, 0, 1'b0);
      repeat (3) @(posedge clk); #1;
      check("busy_idle", {31'd0, busy}, 32'd0);
      check("cnt_basic", {24'd0, frame_cnt}, 32'd1);

      // Same frame with two idle cycles between bits
      send_frame(8'hA5, 2, 1'b0);
      repeat (3) @(posedge clk); #1;
      check("cnt_gaps", {24'd0, frame_cnt}, 32'd2);

      // False headers: 1100 1011 then zeros must not start a frame
      begin
         logic [15:0] s;
         s = 16'b1100_1011_0000_0000;
         for (int i = 15; i >= 0; i--) send_bit(s[i], 0);
      end
      check("false_hdr_busy", {31'd0, busy}, 32'd0);
      check("false_hdr_cnt", {24'd0, frame_cnt}, 32'd2);

      // Overlap: 1101101 + ones -> payload 1,0,1,1,1,1,1,1 = 0xBF
      push_exp(8'hBF, 1'b0);
      begin
         logic [14:0] s;
         s = 15'b1101101_1111_1111;
         for (int i = 14; i >= 10; i--) send_bit(s[i], 0);
         for (int i = 9; i >= 3; i--) send_bit(s[i], 0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
         send_bit(1'b1, 0);
`endif
         for (int i = 2; i >= 0; i--) send_bit(s[i], 0);
      end
      repeat (4) send_bit(1'b0, 0);
      check("overlap_cnt", {24'd0, frame_cnt}, 32'd3);

      // Reset mid-frame: header plus 4 payload bits, then reset
      send_header(0);
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
      do_reset(1);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_cnt", {24'd0, frame_cnt}, 32'd0);
      repeat (3) @(posedge clk); #1;
      check("midrst_cnt_hold", {24'd0, frame_cnt}, 32'd0);
      check("midrst_valid", {31'd0, valid}, 32'd0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
      // Parity: 0xA5 has even weight, so bit 1 is an error and bit 0 is not
      send_frame(8'hA5, 0, 1'b1);
      send_frame(8'hA5, 0, 1'b0);
      repeat (3) @(posedge clk); #1;
      do_reset(1);
`endif

      // 256 back-to-back frames, payload = index; count wraps to 0
      for (int i = 0; i < 256; i++) send_frame(8'(i), 0, 1'b0);
      repeat (3) @(posedge clk); #1;
      check("wrap_cnt", {24'd0, frame_cnt}, 32'd0);
      check("wrap_data", {24'd0, data_o}, 32'd255);

      // Drain: every expected frame must have been seen
      repeat (10) @(posedge clk); #1;
      check("sb_empty", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_serial_frame_rx
